// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader: turns asynchronous front-panel inputs into one-cycle RAM writes and holds the CPU while programming.
// Latency: strobe edge to ram_we_o is SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles; cpu_halt_o follows prog_mode after SYNC_STAGES+1.
// Backpressure: none; a second write needs a debounced release first. Optional PROG_LOADER_AUTO_INC_EN replaces addr_i with an internal pointer.
module prog_loader #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ADDR_W          = 4,
   parameter int DATA_W          = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_mode_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              wr_strobe_i,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_data_o,
   output logic              ram_we_o,
   output logic              cpu_halt_o,
   output logic              busy_o,
   output logic [4:0]        wr_count_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {IDLE, PRESS, WRITE, RELEASE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [SYNC_STAGES-1:0] pm_sync;
   logic [SYNC_STAGES-1:0] stb_sync;
   logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
   logic                   pm_s, stb_s, pm_d, pm_rise, capture;

   // Per-bit synchronizers for the control lines and the data bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pm_sync  <= '0;
         stb_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
      end else begin
         pm_sync      <= {pm_sync[SYNC_STAGES-2:0], prog_mode_i};
         stb_sync     <= {stb_sync[SYNC_STAGES-2:0], wr_strobe_i};
         data_sync[0] <= data_i;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      end
   end

   assign pm_s    = pm_sync[SYNC_STAGES-1];
   assign stb_s   = stb_sync[SYNC_STAGES-1];
   assign pm_rise = pm_s & ~pm_d;
   assign capture = (state == PRESS) && (state_nxt == WRITE);

`ifdef PROG_LOADER_AUTO_INC_EN
   logic [ADDR_W-1:0] ptr;

   // Write pointer: restarts at 0 on every entry into programming mode, advances once per write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              ptr <= '0;
      else if (pm_rise)        ptr <= '0;
      else if (state == WRITE) ptr <= ptr + ADDR_W'(1);
   end

   wire [ADDR_W-1:0] addr_src = ptr;
`else
   logic [ADDR_W-1:0] addr_sync [SYNC_STAGES];

   // Per-bit synchronizer for the address bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) addr_sync[i] <= '0;
      end else begin
         addr_sync[0] <= addr_i;
         for (int i = 1; i < SYNC_STAGES; i++) addr_sync[i] <= addr_sync[i-1];
      end
   end

   wire [ADDR_W-1:0] addr_src = addr_sync[SYNC_STAGES-1];
`endif

   // FSM state and debounce counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: debounce press, fire one write, debounce release; losing prog_mode aborts except in WRITE
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (pm_s && stb_s) begin
               state_nxt = PRESS;
               cnt_nxt   = CNT_W'(1);
            end
         end
         PRESS: begin
            if (!pm_s || !stb_s) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nxt = WRITE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         WRITE: begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
         end
         RELEASE: begin
            if (!pm_s || cnt == CNT_MAX) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (stb_s) begin
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Decoded outputs: write enable only in WRITE, busy whenever not IDLE
   always_comb begin
      ram_we_o = 1'b0;
      busy_o   = 1'b0;
      if (state == WRITE) ram_we_o = 1'b1;
      if (state != IDLE)  busy_o   = 1'b1;
   end

   // Registered datapath: halt, write capture, and the saturating write counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pm_d       <= 1'b0;
         cpu_halt_o <= 1'b0;
         ram_addr_o <= '0;
         ram_data_o <= '0;
         wr_count_o <= '0;
      end else begin
         pm_d       <= pm_s;
         cpu_halt_o <= pm_s | (state != IDLE);
         if (capture) begin
            ram_addr_o <= addr_src;
            ram_data_o <= data_sync[SYNC_STAGES-1];
         end
         if (pm_rise)
            wr_count_o <= '0;
         else if (capture && wr_count_o != 5'd31)
            wr_count_o <= wr_count_o + 5'd1;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
// tb_prog_loader: random and directed front-panel stimulus against a sample-counting reference model.
// Latency: the model predicts outputs for every cycle; a negedge process compares them.
// Backpressure: not applicable; the bench drives inputs freely.
module tb_prog_loader;

   localparam int S = 2;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       prog_mode = 1'b0;
   logic [3:0] addr = '0;
   logic [7:0] data = '0;
   logic       wr_strobe = 1'b0;
   logic [3:0] ram_addr;
   logic [7:0] ram_data;
   logic       ram_we, cpu_halt, busy;
   logic [4:0] wr_count;

   int errors = 0;
   int checks = 0;
   int we_pulses = 0;

   prog_loader #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .prog_mode_i(prog_mode), .addr_i(addr), .data_i(data),
      .wr_strobe_i(wr_strobe), .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_we_o(ram_we),
      .cpu_halt_o(cpu_halt), .busy_o(busy), .wr_count_o(wr_count)
   );

   always #5 clk = ~clk;

   // Reference model. phase: 0 waiting, 1 counting high samples, 2 writing, 3 counting low samples.
   typedef struct packed {
      int              phase;
      int              run;
      logic [4:0]      cnt;
      logic [3:0]      addr;
      logic [7:0]      data;
      logic            halt;
      logic            pm_prev;
      logic [3:0]      ptr;
      logic [S-1:0]    pm_q;
      logic [S-1:0]    stb_q;
      logic [S-1:0][3:0] a_q;
      logic [S-1:0][7:0] d_q;
   } mdl_t;

   mdl_t mdl;

   function automatic mdl_t mstep(mdl_t m, logic pm_in, logic stb_in, logic [3:0] a_in, logic [7:0] d_in);
      mdl_t n;
      logic pm_s, stb_s;
      n     = m;
      pm_s  = m.pm_q[S-1];
      stb_s = m.stb_q[S-1];
      n.pm_q  = {m.pm_q[S-2:0], pm_in};
      n.stb_q = {m.stb_q[S-2:0], stb_in};
      n.a_q   = {m.a_q[S-2:0], a_in};
      n.d_q   = {m.d_q[S-2:0], d_in};
      n.halt    = pm_s || (m.phase != 0);
      n.pm_prev = pm_s;
      case (m.phase)
         0: if (pm_s && stb_s) begin n.phase = 1; n.run = 1; end
         1: begin
            // a press is accepted on the (D+1)-th consecutive high sample
            if (!pm_s || !stb_s) n.phase = 0;
            else if (m.run + 1 > D) begin
               n.phase = 2;
`ifdef PROG_LOADER_AUTO_INC_EN
               n.addr = m.ptr;
`else
               n.addr = m.a_q[S-1];
`endif
               n.data = m.d_q[S-1];
               n.cnt  = (m.cnt == 5'd31) ? 5'd31 : m.cnt + 5'd1;
            end else n.run = m.run + 1;
         end
         2: begin n.phase = 3; n.run = 0; n.ptr = m.ptr + 4'd1; end
         default: begin
            if (!pm_s || m.run == D) n.phase = 0;
            else n.run = stb_s ? 0 : m.run + 1;
         end
      endcase
      if (pm_s && !m.pm_prev) begin n.cnt = '0; n.ptr = '0; end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mdl <= '0;
      else        mdl <= mstep(mdl, prog_mode, wr_strobe, addr, data);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, plus a write-pulse counter
   always @(negedge clk) begin
      if (ram_we) we_pulses <= we_pulses + 1;
      chk("m_we",    32'(ram_we),   32'(mdl.phase == 2));
      chk("m_busy",  32'(busy),     32'(mdl.phase != 0));
      chk("m_halt",  32'(cpu_halt), 32'(mdl.halt));
      chk("m_count", 32'(wr_count), 32'(mdl.cnt));
      chk("m_addr",  32'(ram_addr), 32'(mdl.addr));
      chk("m_data",  32'(ram_data), 32'(mdl.data));
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr_once(input logic [3:0] a, input logic [7:0] d);
      addr = a; data = d; wr_strobe = 1'b1;
      step(12);
      wr_strobe = 1'b0;
      step(12);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, lat;
      logic any_busy, any_halt, found;

      // Reset state
      step(3);
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_halt", 32'(cpu_halt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(wr_count), 0);
      rst_n = 1'b1;
      step(2);

      // Clean write: strobe held high 20 cycles
      prog_mode = 1'b1;
      step(5);
      chk("halt_on", 32'(cpu_halt), 1);
      addr = 4'hA; data = 8'h3C;
      p0 = we_pulses; lat = -1;
      wr_strobe = 1'b1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (ram_we) begin lat = n; break; end
      end
      chk("clean_latency", 32'(lat), 7);
      chk("clean_addr", 32'(ram_addr), 32'h0A);
      chk("clean_data", 32'(ram_data), 32'h3C);
      chk("clean_count", 32'(wr_count), 1);
      step(13);
      wr_strobe = 1'b0;
      step(12);
      chk("clean_pulses", 32'(we_pulses - p0), 1);
      chk("clean_idle", 32'(busy), 0);

      // Bounce on press and on release
      p0 = we_pulses;
      addr = 4'h3; data = 8'hC5;
      for (int i = 0; i < 6; i++) begin wr_strobe = (i % 2 == 0); step(1); end
      wr_strobe = 1'b0;
      step(3);
      chk("bounce_nowrite", 32'(we_pulses - p0), 0);
      wr_strobe = 1'b1;
      step(14);
      chk("bounce_one", 32'(we_pulses - p0), 1);
      chk("bounce_data", 32'(ram_data), 32'hC5);
      for (int i = 0; i < 8; i++) begin wr_strobe = (i % 2 == 1); step(1); end
      wr_strobe = 1'b0;
      step(12);
      chk("bounce_release", 32'(we_pulses - p0), 1);
      chk("bounce_count", 32'(wr_count), 2);

      // Gating: strobe ignored without prog_mode
      prog_mode = 1'b0;
      step(5);
      p0 = we_pulses; any_busy = 1'b0; any_halt = 1'b0;
      wr_strobe = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         any_busy |= busy; any_halt |= cpu_halt;
      end
      wr_strobe = 1'b0;
      step(3);
      chk("gate_busy", 32'(any_busy), 0);
      chk("gate_halt", 32'(any_halt), 0);
      chk("gate_nowrite", 32'(we_pulses - p0), 0);
      lat = -1;
      prog_mode = 1'b1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (cpu_halt) begin lat = n; break; end
      end
      chk("halt_latency", 32'(lat), S + 1);
      chk("rise_clears_count", 32'(wr_count), 0);

      // Abort: prog_mode drops during PRESS
      step(4);
      p0 = we_pulses;
      wr_strobe = 1'b1;
      step(3);
      prog_mode = 1'b0;
      step(8);
      wr_strobe = 1'b0;
      step(10);
      chk("abort_nowrite", 32'(we_pulses - p0), 0);
      chk("abort_idle", 32'(busy), 0);

      // Saturation after 33 writes
      prog_mode = 1'b1;
      step(4);
      for (int i = 0; i < 33; i++) wr_once(4'($urandom), 8'($urandom));
      chk("sat_count", 32'(wr_count), 31);

`ifdef PROG_LOADER_AUTO_INC_EN
      // Pointer addressing ignores addr_i and wraps
      prog_mode = 1'b0; step(4); prog_mode = 1'b1; step(4);
      for (int i = 0; i < 17; i++) begin
         wr_once(4'h5, 8'(i));
         chk("auto_addr", 32'(ram_addr), 32'(i % 16));
      end
      prog_mode = 1'b0; step(4); prog_mode = 1'b1; step(4);
      wr_once(4'h5, 8'h77);
      chk("auto_restart", 32'(ram_addr), 0);
`endif

      // Random front-panel activity
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) prog_mode = ~prog_mode;
         if ($urandom_range(0, 3) == 0)  wr_strobe = ~wr_strobe;
         if ($urandom_range(0, 2) == 0)  begin addr = 4'($urandom); data = 8'($urandom); end
         step(1);
      end
      wr_strobe = 1'b0;
      step(15);

      // Asynchronous reset in the middle of a write
      prog_mode = 1'b1;
      step(4);
      wr_strobe = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (ram_we) begin found = 1'b1; break; end
      end
      chk("rst_wait_write", 32'(found), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_we", 32'(ram_we), 0);
      chk("arst_halt", 32'(cpu_halt), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_count", 32'(wr_count), 0);
      wr_strobe = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(12);
      chk("arst_idle", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
